ip_extslot_multi: RTL
=====================

// Module: ip_extslot_multi
// PURPOSE
//  Expanded-slot controller for NUM_SLOTS primary slots. Each expanded primary slot has its
//  own secondary-slot register at EXT_ADDR. The register is written directly and read back
//  inverted (MSX convention) after a programmable read latency.
//  Decodes page -> secondary slot and drives NUM_SLOTS*4 secondary /SLTSL-equivalent selects.
//  Sits between the MSX-50BUS slave interface and the per-subslot device blocks.
// PARAMETERS
//  NUM_SLOTS      2         number of primary slots handled (1..4)
//  SLOT_EXPANDED  4'b1111   bit s=1: primary slot s is expanded; bit s=0: pass-through
//  EXT_ADDR       16'hFFFF  address of the secondary-slot register
//  RESET_VALUE    8'h00     reset value of every slot register
//  READ_LATENCY   1         clocks from read strobe to bus_read_ready (1..8)
// PORTS
//  clk              in   1            system clock
//  n_reset          in   1            synchronous active-low reset
//  bus_address      in   16           bus address
//  bus_io_cs        out  1            constant 0 (no I/O space)
//  bus_memory_cs    out  1            constant 1 (claims memory space)
//  bus_read_ready   out  1            one-cycle read data valid pulse
//  bus_read_data    out  8            read data; 8'h00 when bus_read_ready=0
//  bus_write_data   in   8            write data
//  bus_read         in   1            one-cycle read strobe
//  bus_write        in   1            one-cycle write strobe
//  bus_io           in   1            I/O cycle qualifier
//  bus_memory       in   1            memory cycle qualifier
//  bus_primary_sel  in   NUM_SLOTS    primary slot select, one-hot expected
//  extslot_memory   out  NUM_SLOTS*4  bit s*4+k: primary s, secondary k selected
// BEHAVIOUR
//  - Reset: every ff_reg[s] <= RESET_VALUE; read FSM -> IDLE; counter 0;
//    bus_read_ready=0; bus_read_data=8'h00.
//  - Slot index: lowest set bit of bus_primary_sel. No bit set -> no register access.
//  - hit = bus_memory & bus_address==EXT_ADDR & any sel bit & SLOT_EXPANDED[index].
//  - Write: hit & bus_write -> ff_reg[index] <= bus_write_data on the next edge.
//    Other slots' registers hold.
//  - Read FSM:
//    - IDLE: on hit & bus_read, capture ~ff_reg[index] (pre-write value if a write occurs
//      in the same cycle).
//      - If READ_LATENCY==1: go to READY.
//      - Otherwise: load cnt=READ_LATENCY-2 and go to WAIT.
//    - WAIT: decrement cnt each clock; at cnt==0 go to READY. New read strobes are ignored.
//    - READY: bus_read_ready=1 and bus_read_data=captured value for exactly one cycle, then IDLE.
//      A hit read in this cycle is ignored.
//    - Ready rises READ_LATENCY clocks after the strobe edge.
//    - Reset in WAIT or READY aborts the read: no ready pulse is produced.
//  - Selects (combinational, use the current register value):
//    - Page p = bus_address[15:14]; secondary k = ff_reg[s][2p+1:2p].
//    - Expanded s: extslot_memory[s*4+k] = bus_memory & bus_primary_sel[s] & ~(addr==EXT_ADDR).
//      The other three bits of slot s are 0.
//    - Non-expanded s: bit s*4 = bus_memory & bus_primary_sel[s]; bits s*4+1..3 = 0.
//      EXT_ADDR is not decoded and passes through to secondary 0.
//    - bus_io=1 or bus_memory=0: all selects 0.
//  - A write to EXT_ADDR changes the selects from the next clock onward.
// TESTING
//  - Reset: RESET_VALUE=8'h00, sel=01, read 0x4000 -> extslot_memory bit0=1.
//    Read of FFFF -> data 8'hFF after READ_LATENCY clocks; all selects 0 during the FFFF access.
//  - Slot isolation: write 8'hE4 to slot0 and 8'h1B to slot1.
//    - sel=01: addresses 0x0000/0x4000/0x8000/0xC000 -> bits 0/1/2/3.
//    - sel=10: same addresses -> bits 7/6/5/4.
//    - Read-back: slot0 gives 8'h1B, slot1 gives 8'hE4.
//  - Latency: READ_LATENCY=4, read strobe at cycle t -> ready high only at t+4 with ~reg.
//    A second strobe at t+2 is ignored; exactly one pulse occurs.
//  - Same-cycle write+read to slot0 (reg=8'h00, write 8'h55) -> read returns 8'hFF.
//    A following read returns 8'hAA.
//  - Pass-through: SLOT_EXPANDED=4'b0001, sel=10, write 8'h55 to FFFF.
//    No register changes; bit4=1 and bit5..7=0; no bus_read_ready on a read.
//  - Reset asserted in WAIT (READ_LATENCY=3) -> no ready pulse.
//    Registers return to RESET_VALUE; the FSM accepts a new read after reset.

Source files
------------

// File: rtl/ip_extslot_multi_if.sv
// Bus bundle between the MSX-50BUS slave port and the expanded-slot controller.
interface ip_extslot_multi_if #(
  parameter int NUM_SLOTS = 2
);
  logic [15:0]            bus_address;
  logic                   bus_io_cs;
  logic                   bus_memory_cs;
  logic                   bus_read_ready;
  logic [7:0]             bus_read_data;
  logic [7:0]             bus_write_data;
  logic                   bus_read;
  logic                   bus_write;
  logic                   bus_io;
  logic                   bus_memory;
  logic [NUM_SLOTS-1:0]   bus_primary_sel;
  logic [NUM_SLOTS*4-1:0] extslot_memory;

  modport master (
    output bus_address, bus_write_data, bus_read, bus_write, bus_io, bus_memory,
           bus_primary_sel,
    input  bus_io_cs, bus_memory_cs, bus_read_ready, bus_read_data, extslot_memory
  );

  modport slave (
    input  bus_address, bus_write_data, bus_read, bus_write, bus_io, bus_memory,
           bus_primary_sel,
    output bus_io_cs, bus_memory_cs, bus_read_ready, bus_read_data, extslot_memory
  );
endinterface

// File: rtl/ip_extslot_multi.sv
// Expanded-slot controller: per-primary-slot secondary-slot registers with inverted,
// latency-programmable read-back and page -> secondary select decode.
//
// state    | meaning
// ST_IDLE  | waiting for a read hit on the slot register
// ST_WAIT  | read captured, counting down the remaining latency
// ST_READY | read_ready pulse with captured data
module ip_extslot_multi #(
  parameter int          NUM_SLOTS     = 2,
  parameter logic [3:0]  SLOT_EXPANDED = 4'b1111,
  parameter logic [15:0] EXT_ADDR      = 16'hFFFF,
  parameter logic [7:0]  RESET_VALUE   = 8'h00,
  parameter int          READ_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  ip_extslot_multi_if.slave bus
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [2:0] CNT_LOAD = 3'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

  state_t           state;
  logic [2:0]       cnt;
  logic [7:0]       ff_reg [NUM_SLOTS];
  logic [7:0]       cap_data;
  logic             ready_q;
  logic [7:0]       rdata_q;
  logic [IDX_W-1:0] slot_idx;
  logic             idx_expanded;
  logic             ext_match;
  logic             hit;
  logic [1:0]       page;
  logic [NUM_SLOTS*4-1:0] sel_out;

  assign ext_match = (bus.bus_address == EXT_ADDR);
  assign page      = bus.bus_address[15:14];

  // Lowest set select bit wins; scanning downward leaves the lowest one in place.
  always_comb begin
    slot_idx     = '0;
    idx_expanded = 1'b0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (bus.bus_primary_sel[s]) begin
        slot_idx     = IDX_W'(s);
        idx_expanded = SLOT_EXPANDED[s];
      end
    end
  end

  assign hit = bus.bus_memory & ext_match & (|bus.bus_primary_sel) & idx_expanded;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) ff_reg[s] <= RESET_VALUE;
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      cap_data <= 8'h00;
      ready_q  <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      if (hit && bus.bus_write) ff_reg[slot_idx] <= bus.bus_write_data;
      ready_q <= 1'b0;
      rdata_q <= 8'h00;
      case (state)
        ST_IDLE: begin
          if (hit && bus.bus_read) begin
            // Captured from the pre-write value when a write hits in the same cycle.
            cap_data <= ~ff_reg[slot_idx];
            if (READ_LATENCY == 1) begin
              state   <= ST_READY;
              ready_q <= 1'b1;
              rdata_q <= ~ff_reg[slot_idx];
            end else begin
              cnt   <= CNT_LOAD;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 3'd0) begin
            state   <= ST_READY;
            ready_q <= 1'b1;
            rdata_q <= cap_data;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_READY: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sel_out = '0;
    if (bus.bus_memory && !bus.bus_io) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (SLOT_EXPANDED[s]) begin
          if (bus.bus_primary_sel[s] && !ext_match)
            sel_out[s*4 + int'(ff_reg[s][{page, 1'b0} +: 2])] = 1'b1;
        end else begin
          sel_out[s*4] = bus.bus_primary_sel[s];
        end
      end
    end
  end

  assign bus.extslot_memory = sel_out;
  assign bus.bus_io_cs      = 1'b0;
  assign bus.bus_memory_cs  = 1'b1;
  assign bus.bus_read_ready = ready_q;
  assign bus.bus_read_data  = rdata_q;

endmodule
